// File: rtl/instruction_store_pkg.sv
// Shared definitions for the instruction store: opcode encodings, the
// default NOP word and the control FSM state type.
package instruction_store_pkg;

  typedef enum logic [3:0] {
    OP_ADD      = 4'b0000,
    OP_SUBTRACT = 4'b0001,
    OP_AND      = 4'b0010,
    OP_OR       = 4'b0011,
    OP_XOR      = 4'b0100,
    OP_NOT      = 4'b0101,
    OP_LOAD     = 4'b0111,
    OP_STOREMEM = 4'b1000,
    OP_STORERF  = 4'b1001,
    OP_NOP      = 4'b1111
  } opcode_e;

  // NOP opcode in the low nibble, every other bit zero.
  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h000F;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_LOAD
  } state_e;

endpackage

// File: rtl/instruction_store_if.sv
// Fetch and load-burst signal bundle of the instruction store.
//   master : fetch/load requester (drives requests and burst data)
//   slave  : instruction store (drives fetch results, handshake and status)
interface instruction_store_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
);
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic               ld_start;
  logic [ADDR_W-1:0]  ld_base;
  logic               ld_valid;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               ld_done;
  logic               ld_wrap;
  logic               busy;

  modport master (
    output fetch_req, fetch_addr, ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  fetch_valid, fetch_instr, ld_ready, ld_done, ld_wrap, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, ld_start, ld_base, ld_valid, ld_data, ld_last,
    output fetch_valid, fetch_instr, ld_ready, ld_done, ld_wrap, busy
  );
endinterface

// File: rtl/instruction_store_ram.sv
// Instruction storage array: one synchronous write port, one synchronous
// read port. No reset; contents are initialised by the parent's clear pass.
//   clk     : clock
//   we_i    : write enable      waddr_i/wdata_i : write address/data
//   re_i    : read enable       raddr_i         : read address
//   rdata_o : registered read data (valid the cycle after re_i)
module istore_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/instruction_store.sv
// Instruction store: after reset, clears every word to NOP, then serves
// single-cycle-latency fetches and accepts load bursts that overwrite a
// run of consecutive (wrapping) addresses.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch port (req/addr -> valid/instr), load burst port
//              (start/base, valid/data/last -> ready/done/wrap), busy status
module instruction_store
  import instruction_store_pkg::*;
#(
  parameter int                 ADDR_W   = 5,
  parameter int                 INSTR_W  = 16,
  parameter int                 DEPTH    = 2**ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_store_if.slave    bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               wrap_q, wrap_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               done_q, done_d;

  logic               ram_we, ram_re;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [INSTR_W-1:0] ram_wdata, ram_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      ptr_q         <= '0;
      wrap_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      ptr_q         <= ptr_d;
      wrap_q        <= wrap_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    ptr_d         = ptr_q;
    wrap_d        = wrap_q;
    fetch_valid_d = 1'b0;
    done_d        = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // A start in the same cycle as a fetch still lets the fetch complete.
        fetch_valid_d = bus.fetch_req;
        if (bus.ld_start) begin
          state_d = S_LOAD;
          ptr_d   = bus.ld_base;
          wrap_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.ld_valid) begin
          if (ptr_q == LAST_ADDR) begin
            ptr_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
          if (bus.ld_last) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Output / memory-control logic
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = NOP_WORD;
    ram_re    = 1'b0;
    bus.ld_ready = 1'b0;
    bus.busy     = 1'b1;
    unique case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
      end
      S_RUN: begin
        bus.busy = 1'b0;
        ram_re   = bus.fetch_req;
      end
      S_LOAD: begin
        bus.ld_ready = 1'b1;
        ram_we       = bus.ld_valid;
        ram_waddr    = ptr_q;
        ram_wdata    = bus.ld_data;
      end
      default: ;
    endcase
  end

  istore_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (bus.fetch_addr),
    .rdata_o (ram_rdata)
  );

  // The read register is not reset, so a non-served cycle is masked to NOP.
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_instr = fetch_valid_q ? ram_rdata : NOP_WORD;
  assign bus.ld_done     = done_q;
  assign bus.ld_wrap     = wrap_q;
endmodule

// File: tb/tb_instruction_store.sv
module tb_instruction_store;
  localparam int          AW    = 5;
  localparam int          IW    = 16;
  localparam int          DEPTH = 32;
  localparam logic [15:0] NOP   = 16'h000F;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_store_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instruction_store #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  // Reference: what each address must hold, maintained from the rules alone.
  logic [15:0] mem_m [DEPTH];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_start   = 1'b0;
    bus.ld_base    = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
  endtask

  task automatic fetch_one(input int a, output logic v, output logic [15:0] d);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(a);
    step();
    v = bus.fetch_valid;
    d = bus.fetch_instr;
    bus.fetch_req = 1'b0;
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic start_load(input int base);
    bus.ld_start = 1'b1;
    bus.ld_base  = AW'(base);
    step();
    bus.ld_start = 1'b0;
  endtask

  // Streams words into an open burst; gap cycles (valid low, last high) go
  // before every word after the first when gaps is set.
  task automatic load_words(input int base, input logic [15:0] words[$], input bit gaps,
                            output bit ready_ok, output bit done_ok);
    int n;
    n = words.size();
    ready_ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0) begin
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b1;
        bus.ld_data  = 16'($urandom);
        step();
        if (bus.ld_ready !== 1'b1) ready_ok = 1'b0;
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = words[k];
      bus.ld_last  = (k == n - 1);
      if (bus.ld_ready !== 1'b1) ready_ok = 1'b0;
      step();
      mem_m[(base + k) % DEPTH] = words[k];
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    done_ok = (bus.ld_done === 1'b1) && (bus.ld_ready === 1'b0);
    step();
    if (bus.ld_done !== 1'b0) done_ok = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    idle();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fetch_valid got=%b exp=0", bus.fetch_valid); end
    n_cmp++; if (bus.fetch_instr !== NOP) begin n_err++; $display("FAIL reset_fetch_instr got=%h exp=%h", bus.fetch_instr, NOP); end
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready got=%b exp=0", bus.ld_ready); end
    n_cmp++; if (bus.ld_done !== 1'b0) begin n_err++; $display("FAIL reset_ld_done got=%b exp=0", bus.ld_done); end
    n_cmp++; if (bus.ld_wrap !== 1'b0) begin n_err++; $display("FAIL reset_ld_wrap got=%b exp=0", bus.ld_wrap); end
    rst = 1'b0;
    model_clear();
    count_busy(cyc);
    n_cmp++; if (cyc != DEPTH) begin n_err++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", cyc, DEPTH); end
  endtask

  task automatic test_clear_contents();
    // Back-to-back fetches across the whole array.
    for (int i = 0; i < DEPTH; i++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = AW'(i);
      step();
      n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== mem_m[i]) begin
        n_err++; $display("FAIL clear_fetch[%0d] got=%b/%h exp=1/%h", i, bus.fetch_valid, bus.fetch_instr, mem_m[i]);
      end
    end
    bus.fetch_req = 1'b0;
    step();
    n_cmp++; if (bus.fetch_valid !== 1'b0 || bus.fetch_instr !== NOP) begin
      n_err++; $display("FAIL idle_fetch got=%b/%h exp=0/%h", bus.fetch_valid, bus.fetch_instr, NOP);
    end
  endtask

  task automatic test_load_basic();
    logic [15:0] w[$];
    bit rok, dok;
    logic v;
    logic [15:0] d;
    start_load(3);
    n_cmp++; if (bus.ld_ready !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL load_enter ready/busy got=%b/%b exp=1/1", bus.ld_ready, bus.busy);
    end
    w = '{16'h0000, 16'h0029};
    load_words(3, w, 1'b0, rok, dok);
    n_cmp++; if (!rok) begin n_err++; $display("FAIL basic_ready got=0 exp=1"); end
    n_cmp++; if (!dok) begin n_err++; $display("FAIL basic_done_pulse got=0 exp=1"); end
    n_cmp++; if (bus.ld_wrap !== 1'b0) begin n_err++; $display("FAIL basic_wrap got=%b exp=0", bus.ld_wrap); end
    fetch_one(3, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 16'h0000) begin n_err++; $display("FAIL basic_fetch3 got=%b/%h exp=1/0000", v, d); end
    fetch_one(4, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 16'h0029) begin n_err++; $display("FAIL basic_fetch4 got=%b/%h exp=1/0029", v, d); end
    fetch_one(5, v, d);
    n_cmp++; if (v !== 1'b1 || d !== 16'h000F) begin n_err++; $display("FAIL basic_fetch5 got=%b/%h exp=1/000f", v, d); end
  endtask

  task automatic test_wrap_gaps();
    logic [15:0] w[$];
    bit rok, dok;
    logic v;
    logic [15:0] d;
    int addrs[5] = '{30, 31, 0, 1, 2};
    for (int k = 0; k < 4; k++) w.push_back(16'($urandom));
    start_load(30);
    load_words(30, w, 1'b1, rok, dok);
    n_cmp++; if (!rok) begin n_err++; $display("FAIL wrap_ready got=0 exp=1"); end
    n_cmp++; if (!dok) begin n_err++; $display("FAIL wrap_done_pulse got=0 exp=1"); end
    n_cmp++; if (bus.ld_wrap !== 1'b1) begin n_err++; $display("FAIL wrap_flag got=%b exp=1", bus.ld_wrap); end
    foreach (addrs[i]) begin
      fetch_one(addrs[i], v, d);
      n_cmp++; if (v !== 1'b1 || d !== mem_m[addrs[i]]) begin
        n_err++; $display("FAIL wrap_fetch[%0d] got=%b/%h exp=1/%h", addrs[i], v, d, mem_m[addrs[i]]);
      end
    end
  endtask

  task automatic test_fetch_during_load();
    logic [15:0] w[$];
    bit rok, dok;
    logic v;
    logic [15:0] d;
    start_load(12);
    // Fetch, second start and a lone ld_last all arrive mid-burst.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(3);
    bus.ld_start   = 1'b1;
    bus.ld_base    = AW'(20);
    bus.ld_last    = 1'b1;
    step();
    n_cmp++; if (bus.fetch_valid !== 1'b0 || bus.fetch_instr !== NOP) begin
      n_err++; $display("FAIL load_fetch_drop got=%b/%h exp=0/%h", bus.fetch_valid, bus.fetch_instr, NOP);
    end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL load_ignore_last got=%b exp=1", bus.ld_ready); end
    idle();
    w.push_back(16'($urandom));
    load_words(12, w, 1'b0, rok, dok);
    n_cmp++; if (!dok) begin n_err++; $display("FAIL ignore_done_pulse got=0 exp=1"); end
    fetch_one(12, v, d);
    n_cmp++; if (d !== mem_m[12]) begin n_err++; $display("FAIL ignore_start_fetch12 got=%h exp=%h", d, mem_m[12]); end
    fetch_one(20, v, d);
    n_cmp++; if (d !== mem_m[20]) begin n_err++; $display("FAIL ignore_start_fetch20 got=%h exp=%h", d, mem_m[20]); end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    logic v;
    logic [15:0] d;
    start_load(8);
    for (int k = 0; k < 2; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'($urandom) | 16'h0100;
      step();
    end
    bus.ld_valid = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++; if (bus.ld_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL midrst ready/busy got=%b/%b exp=0/1", bus.ld_ready, bus.busy);
    end
    rst = 1'b0;
    model_clear();
    count_busy(cyc);
    n_cmp++; if (cyc != DEPTH) begin n_err++; $display("FAIL midrst_clear_cycles got=%0d exp=%0d", cyc, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      fetch_one(i, v, d);
      n_cmp++; if (v !== 1'b1 || d !== mem_m[i]) begin
        n_err++; $display("FAIL midrst_fetch[%0d] got=%b/%h exp=1/%h", i, v, d, mem_m[i]);
      end
    end
  endtask

  task automatic test_fetch_and_start();
    logic [15:0] w[$];
    bit rok, dok;
    logic v;
    logic [15:0] d;
    w = '{16'($urandom), 16'($urandom)};
    start_load(6);
    load_words(6, w, 1'b0, rok, dok);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(6);
    bus.ld_start   = 1'b1;
    bus.ld_base    = AW'(17);
    step();
    idle();
    n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== mem_m[6]) begin
      n_err++; $display("FAIL both_fetch got=%b/%h exp=1/%h", bus.fetch_valid, bus.fetch_instr, mem_m[6]);
    end
    n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL both_ready got=%b exp=1", bus.ld_ready); end
    w = '{16'($urandom)};
    load_words(17, w, 1'b0, rok, dok);
    n_cmp++; if (!dok) begin n_err++; $display("FAIL both_done_pulse got=0 exp=1"); end
    fetch_one(17, v, d);
    n_cmp++; if (v !== 1'b1 || d !== mem_m[17]) begin n_err++; $display("FAIL both_fetch17 got=%b/%h exp=1/%h", v, d, mem_m[17]); end
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    bit rok, dok, gaps;
    logic v;
    logic [15:0] d;
    int a, base, n;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: begin
          a = $urandom_range(0, DEPTH - 1);
          fetch_one(a, v, d);
          n_cmp++; if (v !== 1'b1 || d !== mem_m[a]) begin
            n_err++; $display("FAIL rnd_fetch[%0d] it=%0d got=%b/%h exp=1/%h", a, it, v, d, mem_m[a]);
          end
        end
        3: begin
          base = $urandom_range(0, DEPTH - 1);
          n    = $urandom_range(1, 6);
          gaps = 1'($urandom);
          w.delete();
          for (int k = 0; k < n; k++) w.push_back(16'($urandom));
          start_load(base);
          load_words(base, w, gaps, rok, dok);
          n_cmp++; if (!rok || !dok) begin
            n_err++; $display("FAIL rnd_burst it=%0d ready_ok/done_ok got=%b/%b exp=1/1", it, rok, dok);
          end
          n_cmp++; if (bus.ld_wrap !== (base + n >= DEPTH)) begin
            n_err++; $display("FAIL rnd_wrap it=%0d base=%0d n=%0d got=%b exp=%b", it, base, n, bus.ld_wrap, (base + n >= DEPTH));
          end
        end
        default: begin
          step();
          n_cmp++; if (bus.fetch_valid !== 1'b0 || bus.fetch_instr !== NOP) begin
            n_err++; $display("FAIL rnd_idle it=%0d got=%b/%h exp=0/%h", it, bus.fetch_valid, bus.fetch_instr, NOP);
          end
        end
      endcase
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_clear_contents();
    test_load_basic();
    test_wrap_gaps();
    test_fetch_during_load();
    test_fetch_and_start();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end
endmodule
